// File: rtl/alu_operand_issue.sv
// Operand-fetch/issue stage feeding an 8-bit combinational ALU, with an 8-entry register file.
// Define ALU_ISSUE_FORWARD_EN to forward the ALU result on a RAW hazard instead of stalling one cycle.
module alu_operand_issue #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int OP_W     = 4,
  parameter int CNT_W    = 16,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [AW-1:0]     instr_rs1,
  input  logic [AW-1:0]     instr_rs2,
  input  logic [AW-1:0]     instr_rd,
  input  logic              ld_valid,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_reg_1,
  output logic [DATA_W-1:0] alu_reg_2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_count
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_ex_valid;
  logic [AW-1:0]     r_ex_rd;
  logic [DATA_W-1:0] r_alu_reg_1;
  logic [DATA_W-1:0] r_alu_reg_2;
  logic [OP_W-1:0]   r_alu_op;
  logic              r_wb_valid;
  logic [AW-1:0]     r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic [CNT_W-1:0]  r_retire_count;

  logic              w_hit_1;
  logic              w_hit_2;
  logic              w_ready;
  logic              w_accept;
  logic [DATA_W-1:0] w_op_1;
  logic [DATA_W-1:0] w_op_2;

  // The instruction in EX writes back on the coming edge; r0 is never a real dependency.
  assign w_hit_1 = r_ex_valid && (r_ex_rd != '0) && (instr_rs1 == r_ex_rd);
  assign w_hit_2 = r_ex_valid && (r_ex_rd != '0) && (instr_rs2 == r_ex_rd);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_op_1 = r_regs[instr_rs1];
    w_op_2 = r_regs[instr_rs2];
`ifdef ALU_ISSUE_FORWARD_EN
    if (w_hit_1) w_op_1 = alu_result;
    if (w_hit_2) w_op_2 = alu_result;
    w_ready = !rst;
`else
    w_ready = !rst && !(w_hit_1 || w_hit_2);
`endif
  end

  assign w_accept    = instr_valid && w_ready;
  assign instr_ready = w_ready;

  // Register file: entry 0 is never written, so it always reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is cleared on reset by design, so this array maps to flops, not RAM.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (ld_valid && (ld_addr != '0)) r_regs[ld_addr] <= ld_data;
      // Issued after the load so that a writeback to the same entry wins.
      if (r_ex_valid && (r_ex_rd != '0)) r_regs[r_ex_rd] <= alu_result;
    end
  end

  // EX and WB pipeline registers plus retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_rd        <= '0;
      r_alu_reg_1    <= '0;
      r_alu_reg_2    <= '0;
      r_alu_op       <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_addr      <= '0;
      r_wb_data      <= '0;
      r_retire_count <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_alu_reg_1 <= w_op_1;
        r_alu_reg_2 <= w_op_2;
        r_alu_op    <= instr_op;
        r_ex_rd     <= instr_rd;
      end
      r_wb_valid <= r_ex_valid;
      if (r_ex_valid) begin
        r_wb_addr      <= r_ex_rd;
        r_wb_data      <= alu_result;
        r_retire_count <= r_retire_count + 1'b1;
      end
    end
  end

  assign alu_reg_1    = r_alu_reg_1;
  assign alu_reg_2    = r_alu_reg_2;
  assign alu_op       = r_alu_op;
  assign wb_valid     = r_wb_valid;
  assign wb_addr      = r_wb_addr;
  assign wb_data      = r_wb_data;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for alu_operand_issue; a small ALU model closes the loop on alu_result.
// Expectations follow ALU_ISSUE_FORWARD_EN where the two builds differ.
module tb_alu_operand_issue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_op = '0;
  logic [2:0] instr_rs1 = '0;
  logic [2:0] instr_rs2 = '0;
  logic [2:0] instr_rd = '0;
  logic       ld_valid = 1'b0;
  logic [2:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [7:0] alu_reg_1;
  logic [7:0] alu_reg_2;
  logic [3:0] alu_op;
  logic [7:0] alu_result;
  logic       wb_valid;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic [15:0] retire_count;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd3;

  alu_operand_issue dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_reg_1(alu_reg_1), .alu_reg_2(alu_reg_2), .alu_op(alu_op), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU.
  always_comb begin
    case (alu_op)
      4'd0:    alu_result = alu_reg_1 + alu_reg_2;
      4'd1:    alu_result = alu_reg_1 - alu_reg_2;
      4'd2:    alu_result = alu_reg_1 & alu_reg_2;
      4'd3:    alu_result = alu_reg_1 | alu_reg_2;
      4'd4:    alu_result = alu_reg_1 ^ alu_reg_2;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [2:0] rd,
                           input logic [2:0] rs1, input logic [2:0] rs2);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
  endtask

  int acc;
  int cyc;

  initial begin
    // Reset state.
    step(); step();
    check("rst_ready", instr_ready, 1'b0);
    check("rst_alu1", alu_reg_1, 8'h00);
    check("rst_wbv", wb_valid, 1'b0);
    check("rst_cnt", retire_count, 16'd0);
    rst = 1'b0;
    #1 check("ready_after_rst", instr_ready, 1'b1);

    // Basic add: r3 = r1 + r2 = 8.
    load(3'd1, 8'd3);
    load(3'd2, 8'd5);
    set_instr(OP_ADD, 3'd3, 3'd1, 3'd2);
    step();
    check("add_alu1", alu_reg_1, 8'd3);
    check("add_alu2", alu_reg_2, 8'd5);
    check("add_op", alu_op, OP_ADD);
    check("add_wbv_early", wb_valid, 1'b0);

    // Dependent add: r4 = r3 + r3 = 16.
    set_instr(OP_ADD, 3'd4, 3'd3, 3'd3);
    #1;
`ifdef ALU_ISSUE_FORWARD_EN
    check("dep_ready", instr_ready, 1'b1);
    step();
    check("add_wbv", wb_valid, 1'b1);
    check("add_wba", wb_addr, 3'd3);
    check("add_wbd", wb_data, 8'd8);
    check("add_cnt", retire_count, 16'd1);
    check("fwd_alu1", alu_reg_1, 8'd8);
    check("fwd_alu2", alu_reg_2, 8'd8);
    instr_valid = 1'b0;
`else
    check("stall_ready", instr_ready, 1'b0);
    step();
    check("add_wbv", wb_valid, 1'b1);
    check("add_wba", wb_addr, 3'd3);
    check("add_wbd", wb_data, 8'd8);
    check("add_cnt", retire_count, 16'd1);
    check("stall_end_ready", instr_ready, 1'b1);
    step();
    check("dep_alu1", alu_reg_1, 8'd8);
    check("dep_alu2", alu_reg_2, 8'd8);
    check("dep_wbv_gap", wb_valid, 1'b0);
    instr_valid = 1'b0;
`endif
    step();
    check("dep_wbd", wb_data, 8'd16);
    check("dep_wba", wb_addr, 3'd4);
    check("dep_cnt", retire_count, 16'd2);

    // 8-bit wrap: 200 + 100 = 44.
    load(3'd1, 8'd200);
    load(3'd2, 8'd100);
    set_instr(OP_ADD, 3'd5, 3'd1, 3'd2);
    step();
    instr_valid = 1'b0;
    step();
    check("wrap_wbd", wb_data, 8'd44);
    check("wrap_cnt", retire_count, 16'd3);
    step();
    check("idle_wbv", wb_valid, 1'b0);

    // Writeback to r0 is visible on wb_* but r0 still reads 0.
    set_instr(OP_ADD, 3'd0, 3'd1, 3'd2);
    step();
    instr_valid = 1'b0;
    step();
    check("r0_wbv", wb_valid, 1'b1);
    check("r0_wba", wb_addr, 3'd0);
    check("r0_cnt", retire_count, 16'd4);
    set_instr(OP_OR, 3'd6, 3'd0, 3'd0);
    step();
    instr_valid = 1'b0;
    check("r0_read1", alu_reg_1, 8'd0);
    check("r0_read2", alu_reg_2, 8'd0);
    step();
    check("r0_cnt2", retire_count, 16'd5);

    // Load colliding with writeback to r3: writeback wins. Then load r5 during a writeback.
    load(3'd1, 8'd3);
    load(3'd2, 8'd5);
    set_instr(OP_ADD, 3'd3, 3'd1, 3'd2);
    step();
    instr_valid = 1'b0;
    load(3'd3, 8'hAA);
    check("coll_wbd", wb_data, 8'h08);
    set_instr(OP_ADD, 3'd3, 3'd1, 3'd2);
    step();
    instr_valid = 1'b0;
    load(3'd5, 8'hAA);
    check("coll_cnt", retire_count, 16'd7);
    set_instr(OP_OR, 3'd7, 3'd3, 3'd5);
    step();
    instr_valid = 1'b0;
    check("coll_r3", alu_reg_1, 8'h08);
    check("coll_r5", alu_reg_2, 8'hAA);
    step();
    check("coll_or", wb_data, 8'hAA);

    // Load and accept at the same edge: the instruction sees the old r1.
    ld_valid = 1'b1; ld_addr = 3'd1; ld_data = 8'h11;
    set_instr(OP_OR, 3'd2, 3'd1, 3'd0);
    step();
    ld_valid = 1'b0; instr_valid = 1'b0;
    check("nobypass_alu1", alu_reg_1, 8'd3);
    step();
    check("nobypass_cnt", retire_count, 16'd9);

    // Reset with an instruction in EX: it is discarded.
    set_instr(OP_ADD, 3'd6, 3'd1, 3'd2);
    step();
    instr_valid = 1'b0;
    rst = 1'b1;
    #1 check("midrst_ready", instr_ready, 1'b0);
    step();
    check("midrst_wbv", wb_valid, 1'b0);
    check("midrst_cnt", retire_count, 16'd0);
    check("midrst_alu1", alu_reg_1, 8'd0);
    rst = 1'b0;
    step();
    check("midrst_wbv2", wb_valid, 1'b0);
    set_instr(OP_OR, 3'd7, 3'd1, 3'd3);
    step();
    instr_valid = 1'b0;
    check("midrst_r1", alu_reg_1, 8'd0);
    check("midrst_r3", alu_reg_2, 8'd0);
    step();
    check("midrst_cnt2", retire_count, 16'd1);

    // Retire counter wrap: 70000 independent adds after a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    load(3'd1, 8'd1);
    load(3'd2, 8'd2);
    set_instr(OP_ADD, 3'd5, 3'd1, 3'd2);
    acc = 0;
    cyc = 0;
    while (acc < 70000 && cyc < 72000) begin
      if (instr_ready) acc++;
      step();
      cyc++;
    end
    instr_valid = 1'b0;
    check("wrap_accepts", acc, 70000);
    step();
    check("cnt_wrap", retire_count, 16'd4464);
    check("cnt_wrap_wbd", wb_data, 8'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
